// File: rtl/time_set_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clock_set_pkg
// Purpose  : Shared mode encoding, button indices and default timing constants
//            for the clock front-panel input stage.
// Revision : 1.0
// ============================================================================
package clock_set_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2
  } mode_t;

  localparam logic [15:0] c_debounce_cycles_def = 16'd50000;
  localparam logic [23:0] c_repeat_delay_def    = 24'd5000000;
  localparam logic [23:0] c_repeat_period_def   = 24'd1500000;
  localparam logic [23:0] c_blink_half_def      = 24'd3000000;
  localparam logic [27:0] c_idle_timeout_def    = 28'd100000000;

  // Bit positions of the buttons in the conditioned press vector.
  localparam int c_btn_up    = 0;
  localparam int c_btn_down  = 1;
  localparam int c_btn_left  = 2;
  localparam int c_btn_right = 3;
  localparam int c_btn_ctr   = 4;
  localparam int c_num_btns  = 5;

endpackage
`default_nettype wire

// File: rtl/time_set_controller_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Purpose  : Synchronise, debounce and edge-detect one raw button, with an
//            optional hold-to-repeat press generator.
// Revision : 1.0
// ============================================================================
module button_conditioner
  import clock_set_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = c_debounce_cycles_def,
  parameter logic [23:0] REPEAT_DELAY    = c_repeat_delay_def,
  parameter logic [23:0] REPEAT_PERIOD   = c_repeat_period_def,
  parameter bit          REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_press
);

  logic        r_sync1, r_sync2;
  logic        r_level, r_level_d;
  logic        r_press;
  logic [15:0] r_db_cnt;
  logic [23:0] r_rpt_cnt;
  logic        r_rpt_first;
  logic        w_rise, w_repeat;
  logic [23:0] w_rpt_limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level  <= 1'b0;
      r_db_cnt <= '0;
    end else if (r_sync2 == r_level) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DEBOUNCE_CYCLES - 16'd1) begin
      r_level  <= ~r_level;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + 16'd1;
    end
  end

  assign w_rise      = r_level & ~r_level_d;
  assign w_rpt_limit = r_rpt_first ? REPEAT_DELAY : REPEAT_PERIOD;
  assign w_repeat    = REPEAT_EN && r_level && r_level_d &&
                       (r_rpt_cnt == w_rpt_limit - 24'd1);

  // Repeat timer restarts on the initial press; first interval is the delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rpt_cnt   <= '0;
      r_rpt_first <= 1'b1;
    end else if (!REPEAT_EN || !r_level || w_rise) begin
      r_rpt_cnt   <= '0;
      r_rpt_first <= 1'b1;
    end else if (w_repeat) begin
      r_rpt_cnt   <= '0;
      r_rpt_first <= 1'b0;
    end else begin
      r_rpt_cnt   <= r_rpt_cnt + 24'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_level_d <= r_level;
      r_press   <= w_rise | w_repeat;
    end
  end

  assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/time_set_controller.sv
`default_nettype none
// ============================================================================
// Module   : time_set_controller
// Purpose  : Clock front-panel stage: button conditioning, RUN/SET mode FSM,
//            step pulse generation, idle timeout and edit-field blink mask.
// Revision : 1.0
// ============================================================================
module time_set_controller
  import clock_set_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = c_debounce_cycles_def,
  parameter logic [23:0] REPEAT_DELAY    = c_repeat_delay_def,
  parameter logic [23:0] REPEAT_PERIOD   = c_repeat_period_def,
  parameter logic [23:0] BLINK_HALF      = c_blink_half_def,
  parameter logic [27:0] IDLE_TIMEOUT    = c_idle_timeout_def
) (
  input  logic       clk,
  input  logic       btn_reset,
  input  logic       io_btn_up,
  input  logic       io_btn_down,
  input  logic       io_btn_left,
  input  logic       io_btn_right,
  input  logic       io_btn_ctr,
  output logic [1:0] mode,
  output logic       tick_en,
  output logic       min_step,
  output logic       hour_step,
  output logic       step_dec,
  output logic [3:0] blank
);

  logic [c_num_btns-1:0] w_raw, w_press;
  mode_t                 r_mode, w_mode_next;
  logic                  r_min_step, r_hour_step, r_step_dec;
  logic                  w_min_step_n, w_hour_step_n, w_step_dec_n;
  logic [27:0]           r_idle_cnt;
  logic [23:0]           r_blink_cnt;
  logic                  r_phase;
  logic                  w_set_mode, w_timeout, w_mode_chg, w_any_press;
  logic                  w_ctr, w_lr, w_updn;

  assign w_raw = {io_btn_ctr, io_btn_right, io_btn_left, io_btn_down, io_btn_up};

  generate
    for (genvar gi = 0; gi < c_num_btns; gi++) begin : g_btn
      button_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
        .REPEAT_EN       (gi <= c_btn_down)
      ) u_cond (
        .clk     (clk),
        .rst_n   (btn_reset),
        .i_raw   (w_raw[gi]),
        .o_press (w_press[gi])
      );
    end
  endgenerate

  assign w_ctr       = w_press[c_btn_ctr];
  assign w_lr        = w_press[c_btn_left] | w_press[c_btn_right];
  assign w_updn      = w_press[c_btn_up] ^ w_press[c_btn_down];
  assign w_any_press = |w_press;
  assign w_set_mode  = (r_mode == MODE_SET_HOUR) || (r_mode == MODE_SET_MIN);
  // A press in the same cycle as the last idle count wins over the timeout.
  assign w_timeout   = w_set_mode && !w_any_press &&
                       (r_idle_cnt == IDLE_TIMEOUT - 28'd1);
  assign w_mode_chg  = (w_mode_next != r_mode);

  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      r_mode      <= MODE_RUN;
      r_min_step  <= 1'b0;
      r_hour_step <= 1'b0;
      r_step_dec  <= 1'b0;
    end else begin
      r_mode      <= w_mode_next;
      r_min_step  <= w_min_step_n;
      r_hour_step <= w_hour_step_n;
      r_step_dec  <= w_step_dec_n;
    end
  end

  always_comb begin
    w_mode_next   = r_mode;
    w_min_step_n  = 1'b0;
    w_hour_step_n = 1'b0;
    w_step_dec_n  = 1'b0;
    case (r_mode)
      MODE_RUN: begin
        if (w_ctr) w_mode_next = MODE_SET_HOUR;
      end
      MODE_SET_HOUR: begin
        if (w_ctr || w_lr) begin
          w_mode_next = MODE_SET_MIN;
        end else if (w_timeout) begin
          w_mode_next = MODE_RUN;
        end else if (w_updn) begin
          w_hour_step_n = 1'b1;
          w_step_dec_n  = w_press[c_btn_down];
        end
      end
      MODE_SET_MIN: begin
        if (w_ctr || w_timeout) begin
          w_mode_next = MODE_RUN;
        end else if (w_lr) begin
          w_mode_next = MODE_SET_HOUR;
        end else if (w_updn) begin
          w_min_step_n = 1'b1;
          w_step_dec_n = w_press[c_btn_down];
        end
      end
      default: w_mode_next = MODE_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      r_idle_cnt <= '0;
    end else if (!w_set_mode || w_mode_chg || w_any_press) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 28'd1;
    end
  end

  // Field is forced visible on entry and on each step so edits are readable.
  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (!w_set_mode || w_mode_chg || w_min_step_n || w_hour_step_n) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (r_blink_cnt == BLINK_HALF - 24'd1) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + 24'd1;
    end
  end

  always_comb begin
    blank = 4'b0000;
    case (r_mode)
      MODE_SET_HOUR: blank[3:2] = {2{r_phase}};
      MODE_SET_MIN:  blank[1:0] = {2{r_phase}};
      default:       blank      = 4'b0000;
    endcase
  end

  assign mode      = r_mode;
  assign tick_en   = (r_mode == MODE_RUN);
  assign min_step  = r_min_step;
  assign hour_step = r_hour_step;
  assign step_dec  = r_step_dec;

endmodule
`default_nettype wire

// File: tb/tb_time_set_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_time_set_controller
// Purpose  : Self-checking bench: step pulses scored against a queue of
//            expected events, mode/blank/reset checked inline per scenario.
// Revision : 1.0
// ============================================================================
module tb_time_set_controller;

  localparam int D  = 4;
  localparam int RD = 16;
  localparam int RP = 4;
  localparam int BH = 8;
  localparam int IT = 64;

  logic       clk = 1'b0;
  logic       btn_reset = 1'b0;
  logic       b_up = 1'b0, b_down = 1'b0, b_left = 1'b0, b_right = 1'b0, b_ctr = 1'b0;
  logic [1:0] mode;
  logic       tick_en, min_step, hour_step, step_dec;
  logic [3:0] blank;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct packed {
    int   c;
    logic hour;
    logic dec;
  } step_t;
  step_t sb[$];

  time_set_controller #(
    .DEBOUNCE_CYCLES (16'd4),
    .REPEAT_DELAY    (24'd16),
    .REPEAT_PERIOD   (24'd4),
    .BLINK_HALF      (24'd8),
    .IDLE_TIMEOUT    (28'd64)
  ) dut (
    .clk          (clk),
    .btn_reset    (btn_reset),
    .io_btn_up    (b_up),
    .io_btn_down  (b_down),
    .io_btn_left  (b_left),
    .io_btn_right (b_right),
    .io_btn_ctr   (b_ctr),
    .mode         (mode),
    .tick_en      (tick_en),
    .min_step     (min_step),
    .hour_step    (hour_step),
    .step_dec     (step_dec),
    .blank        (blank)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus raised at negedge cyc=c and held h cycles: level is high for
  // internal edges D+2 .. h+1+D; a press at edge p shows as a step at c+p+2.
  function automatic void push_steps(input int c, input int h, input logic hour, input logic dec);
    int p;
    if (h < D) return;
    p = D + 2;
    sb.push_back('{c: c + p + 2, hour: hour, dec: dec});
    p += RD;
    while (p <= h + 1 + D) begin
      sb.push_back('{c: c + p + 2, hour: hour, dec: dec});
      p += RP;
    end
  endfunction

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  always @(negedge clk) begin : mon
    step_t e;
    if (btn_reset) begin
      checks++;
      if (min_step || hour_step) begin
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL step_unexpected cyc=%0d got min=%0b hour=%0b dec=%0b want no step",
                   cyc, min_step, hour_step, step_dec);
        end else begin
          e = sb.pop_front();
          if (cyc !== e.c || hour_step !== e.hour || min_step !== !e.hour || step_dec !== e.dec) begin
            failures++;
            $display("FAIL step_match got cyc=%0d hour=%0b min=%0b dec=%0b want cyc=%0d hour=%0b min=%0b dec=%0b",
                     cyc, hour_step, min_step, step_dec, e.c, e.hour, !e.hour, e.dec);
          end
        end
      end else if (step_dec !== 1'b0) begin
        failures++;
        $display("FAIL step_dec_idle cyc=%0d got=%0b want=0", cyc, step_dec);
      end
    end
  end

  task automatic test_reset();
    btn_reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (mode !== 2'd0) begin failures++; $display("FAIL reset_mode got=%0d want=0", mode); end
    checks++; if (tick_en !== 1'b1) begin failures++; $display("FAIL reset_tick got=%0b want=1", tick_en); end
    checks++; if ({min_step, hour_step, step_dec} !== 3'b000) begin failures++; $display("FAIL reset_steps got=%b want=000", {min_step, hour_step, step_dec}); end
    checks++; if (blank !== 4'b0000) begin failures++; $display("FAIL reset_blank got=%b want=0000", blank); end
    btn_reset = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (mode !== 2'd0) begin failures++; $display("FAIL idle_mode got=%0d want=0", mode); end
    checks++; if (tick_en !== 1'b1) begin failures++; $display("FAIL idle_tick got=%0b want=1", tick_en); end
    checks++; if (blank !== 4'b0000) begin failures++; $display("FAIL idle_blank got=%b want=0000", blank); end
  endtask

  task automatic test_set_hour_repeat();
    int c;
    c = cyc;
    b_ctr = 1'b1;
    wait_until(c + 7);
    checks++; if (mode !== 2'd0) begin failures++; $display("FAIL ctr_early got=%0d want=0", mode); end
    wait_until(c + 8);
    checks++; if (mode !== 2'd1) begin failures++; $display("FAIL ctr_set_hour got=%0d want=1", mode); end
    checks++; if (tick_en !== 1'b0) begin failures++; $display("FAIL set_tick got=%0b want=0", tick_en); end
    checks++; if (blank !== 4'b0000) begin failures++; $display("FAIL entry_blank got=%b want=0000", blank); end
    wait_until(c + 10);
    b_ctr = 1'b0;
    c = cyc;
    push_steps(c, 40, 1'b1, 1'b0);
    b_up = 1'b1;
    wait_until(c + 40);
    b_up = 1'b0;
    wait_until(c + 50);
    checks++; if (sb.size() !== 0) begin failures++; $display("FAIL up_repeat_missing got=%0d pending want=0", sb.size()); end
    checks++; if (mode !== 2'd1) begin failures++; $display("FAIL up_repeat_mode got=%0d want=1", mode); end
  endtask

  task automatic test_conflicts();
    int c;
    c = cyc;
    b_up = 1'b1; b_down = 1'b1;
    wait_until(c + 6);
    b_up = 1'b0; b_down = 1'b0;
    wait_until(c + 20);
    checks++; if (mode !== 2'd1) begin failures++; $display("FAIL updown_mode got=%0d want=1", mode); end
    c = cyc;
    b_ctr = 1'b1; b_up = 1'b1;
    wait_until(c + 7);
    checks++; if (mode !== 2'd1) begin failures++; $display("FAIL ctrup_early got=%0d want=1", mode); end
    wait_until(c + 8);
    checks++; if (mode !== 2'd2) begin failures++; $display("FAIL ctrup_mode got=%0d want=2", mode); end
    b_ctr = 1'b0; b_up = 1'b0;
    wait_until(c + 20);
  endtask

  task automatic test_set_min_down();
    int c;
    c = cyc;
    b_down = 1'b1;
    wait_until(c + 3);
    b_down = 1'b0;
    wait_until(c + 12);
    c = cyc;
    push_steps(c, 10, 1'b0, 1'b1);
    b_down = 1'b1;
    wait_until(c + 10);
    b_down = 1'b0;
    wait_until(c + 20);
    checks++; if (sb.size() !== 0) begin failures++; $display("FAIL down_missing got=%0d pending want=0", sb.size()); end
    checks++; if (mode !== 2'd2) begin failures++; $display("FAIL down_mode got=%0d want=2", mode); end
  endtask

  task automatic test_left_right_blink_timeout();
    int c;
    int e;
    logic [3:0] exp_blank;
    c = cyc;
    b_left = 1'b1;
    wait_until(c + 6);
    b_left = 1'b0;
    wait_until(c + 7);
    checks++; if (mode !== 2'd2) begin failures++; $display("FAIL left_early got=%0d want=2", mode); end
    wait_until(c + 8);
    checks++; if (mode !== 2'd1) begin failures++; $display("FAIL left_mode got=%0d want=1", mode); end
    wait_until(c + 14);
    c = cyc;
    b_right = 1'b1;
    wait_until(c + 6);
    b_right = 1'b0;
    e = c + 8;
    wait_until(e - 1);
    checks++; if (mode !== 2'd1) begin failures++; $display("FAIL right_early got=%0d want=1", mode); end
    for (int k = 0; k < IT; k++) begin
      wait_until(e + k);
      exp_blank = (((k / BH) % 2) == 1) ? 4'b0011 : 4'b0000;
      checks++;
      if (mode !== 2'd2 || blank !== exp_blank) begin
        failures++;
        $display("FAIL blink k=%0d got mode=%0d blank=%b want mode=2 blank=%b", k, mode, blank, exp_blank);
      end
    end
    wait_until(e + IT);
    checks++; if (mode !== 2'd0) begin failures++; $display("FAIL timeout_mode got=%0d want=0", mode); end
    checks++; if (blank !== 4'b0000) begin failures++; $display("FAIL timeout_blank got=%b want=0000", blank); end
    checks++; if (tick_en !== 1'b1) begin failures++; $display("FAIL timeout_tick got=%0b want=1", tick_en); end
  endtask

  task automatic test_reset_mid_repeat();
    int c;
    c = cyc;
    b_ctr = 1'b1;
    wait_until(c + 6);
    b_ctr = 1'b0;
    wait_until(c + 8);
    checks++; if (mode !== 2'd1) begin failures++; $display("FAIL rst_entry got=%0d want=1", mode); end
    c = cyc;
    sb.push_back('{c: c + D + 4, hour: 1'b1, dec: 1'b0});
    sb.push_back('{c: c + D + 4 + RD, hour: 1'b1, dec: 1'b0});
    b_up = 1'b1;
    wait_until(c + D + 4 + RD);
    #2 btn_reset = 1'b0;
    #1;
    checks++;
    if (mode !== 2'd0 || tick_en !== 1'b1 || hour_step !== 1'b0 || min_step !== 1'b0 ||
        step_dec !== 1'b0 || blank !== 4'b0000) begin
      failures++;
      $display("FAIL rst_async got mode=%0d tick=%0b hs=%0b ms=%0b dec=%0b blank=%b want 0 1 0 0 0 0000",
               mode, tick_en, hour_step, min_step, step_dec, blank);
    end
    b_up = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (mode !== 2'd0 || tick_en !== 1'b1 || hour_step !== 1'b0 || min_step !== 1'b0 ||
          step_dec !== 1'b0 || blank !== 4'b0000) begin
        failures++;
        $display("FAIL rst_hold i=%0d got mode=%0d tick=%0b hs=%0b ms=%0b dec=%0b blank=%b want 0 1 0 0 0 0000",
                 i, mode, tick_en, hour_step, min_step, step_dec, blank);
      end
    end
    btn_reset = 1'b1;
    repeat (15) @(negedge clk);
    checks++; if (mode !== 2'd0) begin failures++; $display("FAIL rst_after_mode got=%0d want=0", mode); end
    checks++; if (sb.size() !== 0) begin failures++; $display("FAIL rst_pending got=%0d want=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_set_hour_repeat();
    test_conflicts();
    test_set_min_down();
    test_left_right_blink_timeout();
    test_reset_mid_repeat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got no completion want completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
